pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1) is the clock and rst (input, 1) is the reset.
REQ-002 The data-side ports SHALL be, one per line:
- BranchValidE  input  1  EX holds a conditional branch
- BranchE  input  1  branch resolved taken in EX
- PredTakenE  input  1  prediction carried with the branch from IF
- JalD  input  1  JAL decoded in ID
- JalrE  input  1  JALR in EX
- MemToRegE  input  1  EX instruction is a load
- RdE  input  5  EX destination register
- Rs1D, Rs2D  input  5 each  ID source registers
- RegReadD  input  2  [1] rs1 used, [0] rs2 used
- DCacheMiss  input  1  MEM-stage access missed
- DCacheReady  input  1  miss refill complete
REQ-003 The control outputs SHALL be StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW (output, 1 each). Each segment register uses en = ~StallX and clear = FlushX.
REQ-004 The statistics outputs SHALL be BranchCount and MispredCount (output, 32 each).

Function
REQ-005 The FSM SHALL have 2 states, RUN and MISS, with state encoding internal to the block.
REQ-006 In RUN, when DCacheMiss=1, the next state SHALL be MISS. In that same cycle the outputs SHALL be StallF/D/E/M=1, FlushW=1, and all other outputs 0.
REQ-007 In MISS, the outputs SHALL be StallF/D/E/M=1, FlushW=1, and all other flush outputs 0. This holds in every MISS cycle, including the cycle where DCacheReady=1.
REQ-008 In MISS, DCacheReady=1 SHALL move the state to RUN on the next edge. DCacheMiss SHALL be ignored while in MISS.
REQ-009 Mispredict SHALL be defined as BranchValidE & (BranchE ^ PredTakenE).
REQ-010 In RUN with no miss, mispredict=1 or JalrE=1 SHALL assert FlushD=1 and FlushE=1, with no stalls.
REQ-011 Load-use SHALL be defined as MemToRegE & RdE!=0 & ((RegReadD[1] & Rs1D==RdE) | (RegReadD[0] & Rs2D==RdE)).
REQ-012 In RUN with no miss, no mispredict and no JALR, load-use SHALL assert StallF=1, StallD=1 and FlushE=1.
REQ-013 In RUN, JalD=1 SHALL assert FlushD=1 unless StallD is asserted in the same cycle.
REQ-014 Priority in RUN SHALL be DCacheMiss > mispredict/JALR > load-use > JalD. A lower-priority condition SHALL have no effect when a higher one is active.
REQ-015 In MISS, a mispredict or JALR SHALL NOT flush. EX is frozen, so the condition is re-evaluated after the return to RUN.
REQ-016 All outputs SHALL be combinational from the state and the inputs, with zero-cycle latency.

Reset
REQ-017 With rst=1 at a clk edge, the state SHALL become RUN, and BranchCount and MispredCount SHALL become 0.
REQ-018 While rst=1, the outputs SHALL be FlushD/E/M/W=1, all Stall outputs 0, and StallF=0.
REQ-019 An rst asserted while in MISS SHALL abandon the miss without waiting for DCacheReady.

Configuration
REQ-020 The feature macro SHALL be BRANCH_STAT_EN.
REQ-021 With BRANCH_STAT_EN defined, BranchCount SHALL increment on each RUN-state edge with BranchValidE=1 and no DCacheMiss.
REQ-022 With BRANCH_STAT_EN defined, MispredCount SHALL increment on each such edge where mispredict=1 as well.
REQ-023 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 With BRANCH_STAT_EN undefined, both ports SHALL still exist, be tied to 32'h0, and use no flops.

Verification
REQ-025 Scenario 1 (load-use): MemToRegE=1, RdE=5, Rs1D=5, RegReadD=2'b10 -> StallF=1, StallD=1, FlushE=1, and all others 0.
REQ-026 Scenario 2 (load to x0): same as scenario 1 with RdE=0 -> all outputs 0.
REQ-027 Scenario 3 (mispredict beats load-use): BranchValidE=1, BranchE=1, PredTakenE=0 together with the scenario 1 inputs -> FlushD=1, FlushE=1, stalls 0, MispredCount increments by 1.
REQ-028 Scenario 4 (miss sequence): DCacheMiss pulse, then 3 idle cycles, then DCacheReady=1 for 1 cycle.
- The response SHALL be StallF/D/E/M=1 and FlushW=1 for 5 cycles, then RUN.
- A mispredict held on the inputs during the miss SHALL flush only in the first RUN cycle.
REQ-029 Scenario 5 (reset and wrap):
- rst=1 during MISS -> next cycle is RUN with counters 0.
- With the macro on, preloading 0xFFFFFFFF and then a correct branch -> BranchCount=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall/flush control for a five-stage pipeline with a blocking D-cache miss.
// Optional branch statistics counters are enabled by defining BRANCH_STAT_EN.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        BranchValidE,
    input  logic        BranchE,
    input  logic        PredTakenE,
    input  logic        JalD,
    input  logic        JalrE,
    input  logic        MemToRegE,
    input  logic [4:0]  RdE,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [1:0]  RegReadD,
    input  logic        DCacheMiss,
    input  logic        DCacheReady,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        StallE,
    output logic        FlushE,
    output logic        StallM,
    output logic        FlushM,
    output logic        StallW,
    output logic        FlushW,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);

    typedef enum logic {RUN, MISS} state_t;

    state_t state;
    logic   mispred;
    logic   load_use;
    logic   frozen;

    assign mispred  = BranchValidE & (BranchE ^ PredTakenE);
    assign load_use = MemToRegE & (RdE != 5'd0) &
                      ((RegReadD[1] & (Rs1D == RdE)) |
                       (RegReadD[0] & (Rs2D == RdE)));
    assign frozen   = (state == MISS) | DCacheMiss;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:  if (DCacheMiss)  state <= MISS;
                MISS: if (DCacheReady) state <= RUN;
            endcase
        end
    end

    // Memory-side freeze dominates; EX-stage redirects wait until RUN.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        StallM = 1'b0;
        FlushM = 1'b0;
        StallW = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else if (frozen) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (mispred | JalrE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (JalD) begin
            FlushD = 1'b1;
        end
    end

`ifdef BRANCH_STAT_EN
    logic [31:0] branch_count;
    logic [31:0] mispred_count;
    logic        count_en;

    assign count_en = (state == RUN) & ~DCacheMiss & BranchValidE;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count  <= 32'h0;
            mispred_count <= 32'h0;
        end else if (count_en) begin
            branch_count <= branch_count + 32'd1;
            if (mispred)
                mispred_count <= mispred_count + 32'd1;
        end
    end

    assign BranchCount  = branch_count;
    assign MispredCount = mispred_count;
`else
    assign BranchCount  = 32'h0;
    assign MispredCount = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a rule-level reference model.
// Outputs are compared every cycle at the falling edge; literals pin key cycles.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        BranchValidE, BranchE, PredTakenE, JalD, JalrE, MemToRegE;
    logic [4:0]  RdE, Rs1D, Rs2D;
    logic [1:0]  RegReadD;
    logic        DCacheMiss, DCacheReady;
    logic        StallF, StallD, FlushD, StallE, FlushE;
    logic        StallM, FlushM, StallW, FlushW;
    logic [31:0] BranchCount, MispredCount;

    // Output vector order: SF SD FD SE FE SM FM SW FW
    localparam logic [8:0] V_NONE = 9'b000000000;
    localparam logic [8:0] V_RST  = 9'b001010101;
    localparam logic [8:0] V_MISS = 9'b110101001;
    localparam logic [8:0] V_FLDE = 9'b001010000;
    localparam logic [8:0] V_LU   = 9'b110010000;
    localparam logic [8:0] V_JAL  = 9'b001000000;

    int total = 0;
    int bad   = 0;

    logic [8:0] outv;
    assign outv = {StallF, StallD, FlushD, StallE, FlushE,
                   StallM, FlushM, StallW, FlushW};

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .BranchValidE(BranchValidE), .BranchE(BranchE),
        .PredTakenE(PredTakenE), .JalD(JalD), .JalrE(JalrE),
        .MemToRegE(MemToRegE), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegReadD(RegReadD), .DCacheMiss(DCacheMiss),
        .DCacheReady(DCacheReady),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .StallE(StallE), .FlushE(FlushE), .StallM(StallM),
        .FlushM(FlushM), .StallW(StallW), .FlushW(FlushW),
        .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    always #5 clk = ~clk;

    // Reference model: miss flag plus two wrapping counters
    bit          m_valid = 0;
    bit          m_miss  = 0;
    logic [31:0] m_bc    = 0;
    logic [31:0] m_mc    = 0;

    function automatic bit m_mispred();
        return BranchValidE && (BranchE != PredTakenE);
    endfunction

    function automatic bit m_load_use();
        logic [4:0] src [2];
        bit         used [2];
        bit         hit;
        src[0] = Rs1D;  used[0] = RegReadD[1];
        src[1] = Rs2D;  used[1] = RegReadD[0];
        hit = 0;
        if (MemToRegE && RdE != 0)
            for (int k = 0; k < 2; k++)
                if (used[k] && src[k] == RdE) hit = 1;
        return hit;
    endfunction

    function automatic logic [8:0] m_out();
        if (rst)                     return V_RST;
        if (m_miss || DCacheMiss)    return V_MISS;
        if (m_mispred() || JalrE)    return V_FLDE;
        if (m_load_use())            return V_LU;
        if (JalD)                    return V_JAL;
        return V_NONE;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_miss  = 0;
            m_bc    = 0;
            m_mc    = 0;
        end else if (m_miss) begin
            if (DCacheReady) m_miss = 0;
        end else if (DCacheMiss) begin
            m_miss = 1;
        end else if (BranchValidE) begin
`ifdef BRANCH_STAT_EN
            m_bc = m_bc + 1;
            if (m_mispred()) m_mc = m_mc + 1;
`endif
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if (outv !== m_out()) begin
                bad++;
                $display("FAIL model_out t=%0t: got %b want %b",
                         $time, outv, m_out());
            end
            total++;
            if (BranchCount !== m_bc) begin
                bad++;
                $display("FAIL model_bcount t=%0t: got %h want %h",
                         $time, BranchCount, m_bc);
            end
            total++;
            if (MispredCount !== m_mc) begin
                bad++;
                $display("FAIL model_mcount t=%0t: got %h want %h",
                         $time, MispredCount, m_mc);
            end
        end
    end

    task automatic idle_inputs();
        BranchValidE = 0; BranchE = 0; PredTakenE = 0;
        JalD = 0; JalrE = 0; MemToRegE = 0;
        RdE = 0; Rs1D = 0; Rs2D = 0; RegReadD = 2'b00;
        DCacheMiss = 0; DCacheReady = 0;
    endtask

    // Check outputs mid-cycle against a literal, then advance one cycle
    task automatic cyc(input string name, input logic [8:0] lit);
        @(negedge clk);
        #1;
        total++;
        if (outv !== lit) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, outv, lit);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic chk32(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic load_use_set();
        MemToRegE = 1; RdE = 5; Rs1D = 5; Rs2D = 7; RegReadD = 2'b10;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        cyc("reset_out0", V_RST);
        cyc("reset_out1", V_RST);
        chk32("reset_bcount", BranchCount, 32'h0);
        chk32("reset_mcount", MispredCount, 32'h0);
        rst = 0;
        cyc("idle", V_NONE);

        load_use_set();
        cyc("sc1_load_use_rs1", V_LU);
        Rs1D = 3; Rs2D = 5; RegReadD = 2'b01;
        cyc("load_use_rs2", V_LU);
        Rs1D = 5; Rs2D = 3; RegReadD = 2'b01;
        cyc("rs1_match_unused", V_NONE);
        load_use_set();
        RdE = 0; Rs1D = 0;
        cyc("sc2_load_x0", V_NONE);

        load_use_set();
        BranchValidE = 1; BranchE = 1; PredTakenE = 0;
        cyc("sc3_mispred_over_lu", V_FLDE);
`ifdef BRANCH_STAT_EN
        chk32("sc3_mcount", MispredCount, 32'd1);
`else
        chk32("sc3_mcount_tied", MispredCount, 32'd0);
`endif
        idle_inputs();
        BranchValidE = 1; BranchE = 1; PredTakenE = 1;
        cyc("correct_branch", V_NONE);
        idle_inputs();
        JalrE = 1;
        cyc("jalr", V_FLDE);
        idle_inputs();
        JalD = 1;
        cyc("jald", V_JAL);
        load_use_set();
        cyc("jald_under_lu", V_LU);
        idle_inputs();
        JalD = 1; JalrE = 1;
        cyc("jald_under_jalr", V_FLDE);

        // Scenario 4: miss with a mispredict held in EX throughout
        idle_inputs();
        BranchValidE = 1; BranchE = 0; PredTakenE = 1;
        DCacheMiss = 1;
        cyc("sc4_miss_edge", V_MISS);
        DCacheMiss = 0;
        for (int i = 0; i < 3; i++) cyc("sc4_miss_wait", V_MISS);
        DCacheReady = 1; DCacheMiss = 1;
        cyc("sc4_miss_ready", V_MISS);
        DCacheReady = 0; DCacheMiss = 0;
        cyc("sc4_first_run_flush", V_FLDE);
        idle_inputs();
        cyc("sc4_after", V_NONE);

        // Scenario 5: reset abandons a miss
        DCacheMiss = 1;
        cyc("sc5_miss", V_MISS);
        DCacheMiss = 0;
        cyc("sc5_in_miss", V_MISS);
        rst = 1;
        cyc("sc5_reset_in_miss", V_RST);
        rst = 0;
        cyc("sc5_run_after_rst", V_NONE);
        chk32("sc5_bcount", BranchCount, 32'h0);
        chk32("sc5_mcount", MispredCount, 32'h0);

`ifdef BRANCH_STAT_EN
        force dut.branch_count = 32'hFFFF_FFFF;
        m_bc = 32'hFFFF_FFFF;
        cyc("wrap_preload", V_NONE);
        release dut.branch_count;
        BranchValidE = 1; BranchE = 0; PredTakenE = 0;
        cyc("wrap_branch", V_NONE);
        idle_inputs();
        cyc("wrap_after", V_NONE);
        chk32("wrap_bcount", BranchCount, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
